// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath parameters and types for the 5-stage CPU.
//   DATA_W   - datapath / write-back word width
//   ADDR_W   - register-index width
//   NUM_REGS - architectural register count (width of the write-enable vector)
//   ZERO_REG - index of XZR; the register file never receives a write to it
// Also holds the write-back source selector shared by the MEM/WB stage.
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0]   reg_idx_t;
  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // Loads return memory data; everything else writes back the ALU result.
  function automatic word_t wb_select(input logic  mem_to_reg,
                                      input word_t mem_data,
                                      input word_t alu_result);
    return mem_to_reg ? mem_data : alu_result;
  endfunction

endpackage

// File: rtl/memwb_stage_if.sv
// memwb_stage_if: bundle between the MEM stage / hazard unit and the MEM/WB
// register, plus the write-back bus towards the register file.
//   stall, flush       - pipeline control (hold / insert bubble)
//   in_*               - MEM-stage instruction results
//   WriteData/write_en - shared write-back bus and one-hot register enables
//   fwd_*              - forwarding tap for the EX-stage bypass network
//   retired            - retired-instruction counter (CNT_W bits)
// master: the side driving MEM results and control; slave: the MEM/WB stage.
interface memwb_stage_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_reg_write;
  logic             in_mem_to_reg;
  reg_idx_t         in_rd;
  word_t            in_alu_result;
  word_t            in_mem_data;

  word_t            WriteData;
  reg_mask_t        write_en;
  logic             fwd_valid;
  reg_idx_t         fwd_rd;
  word_t            fwd_data;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_mem_to_reg,
           in_rd, in_alu_result, in_mem_data,
    input  WriteData, write_en, fwd_valid, fwd_rd, fwd_data, retired
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_mem_to_reg,
           in_rd, in_alu_result, in_mem_data,
    output WriteData, write_en, fwd_valid, fwd_rd, fwd_data, retired
  );

endinterface

// File: rtl/memwb_stage_wb_decoder.sv
// wb_decoder: register-index to one-hot write-enable decoder.
//   en       in  - write permitted this cycle
//   idx      in  - destination register index
//   write_en out - NUM_REGS one-hot enables; all zero when en=0 or idx=ZERO_REG
module wb_decoder
  import cpu_pkg::*;
(
  input  logic      en,
  input  reg_idx_t  idx,
  output reg_mask_t write_en
);

  // NOTE: every bit gets a value on every pass through the loop, so no
  // latch can be inferred; a partially assigned vector here would latch.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      write_en[i] = en && (idx == reg_idx_t'(i)) && (i != ZERO_REG);
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline register and write-back driver.
//   clk    in - pipeline clock, state updates on the rising edge
//   reset  in - asynchronous, active-low; clears all stage state immediately
//   bus       - memwb_stage_if.slave: MEM results and stall/flush in;
//               WriteData, one-hot write_en, forwarding tap and the
//               retired-instruction counter out
// Flush beats stall beats normal capture. write_en is suppressed while
// stalled so a held instruction writes the register file once, on its first
// non-stalled cycle; the forwarding tap is deliberately not stall-gated.
module memwb_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  memwb_stage_if.slave  bus
);

  logic             wb_valid;
  logic             wb_reg_write;
  reg_idx_t         wb_rd;
  word_t            wb_data;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             commit;

  // An instruction leaves WB on an edge where it is valid and neither held
  // nor squashed.
  assign retire = wb_valid & ~bus.stall & ~bus.flush;
  assign commit = wb_valid & wb_reg_write & ~bus.stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else if (bus.flush) begin
      // Bubble: rd and data are left as they were.
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else if (!bus.stall) begin
      wb_valid     <= bus.in_valid;
      wb_reg_write <= bus.in_valid & bus.in_reg_write;
      wb_rd        <= bus.in_rd;
      wb_data      <= wb_select(bus.in_mem_to_reg, bus.in_mem_data,
                                bus.in_alu_result);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  wb_decoder u_wb_decoder (
    .en       (commit),
    .idx      (wb_rd),
    .write_en (bus.write_en)
  );

  assign bus.WriteData = wb_data;
  assign bus.fwd_valid = wb_valid & wb_reg_write & (wb_rd != reg_idx_t'(ZERO_REG));
  assign bus.fwd_rd    = wb_rd;
  assign bus.fwd_data  = wb_data;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_memwb_stage.sv
// tb_memwb_stage: scoreboard bench for memwb_stage.
// The stimulus process drives one instruction slot per cycle just after the
// rising edge, advances a behavioural model of the stage by one edge and
// pushes the outputs it predicts for that cycle. The monitor samples the DUT
// on every falling edge and compares against the queue head.
// A second instance with a 4-bit counter shares all inputs so the modular
// wrap of the retired counter is exercised many times.
module tb_memwb_stage;
  import cpu_pkg::*;

  typedef struct {
    logic     stall;
    logic     flush;
    logic     valid;
    logic     reg_write;
    logic     mem_to_reg;
    reg_idx_t rd;
    word_t    alu;
    word_t    mem;
  } stim_t;

  typedef struct {
    word_t       data;
    reg_mask_t   we;
    logic        fv;
    reg_idx_t    frd;
    logic [31:0] ret;
    logic [3:0]  ret4;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memwb_stage_if #(.CNT_W(32)) bus ();
  memwb_stage_if #(.CNT_W(4))  bus4 ();

  assign bus4.stall         = bus.stall;
  assign bus4.flush         = bus.flush;
  assign bus4.in_valid      = bus.in_valid;
  assign bus4.in_reg_write  = bus.in_reg_write;
  assign bus4.in_mem_to_reg = bus.in_mem_to_reg;
  assign bus4.in_rd         = bus.in_rd;
  assign bus4.in_alu_result = bus.in_alu_result;
  assign bus4.in_mem_data   = bus.in_mem_data;

  memwb_stage #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  memwb_stage #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];

  // Behavioural model: what the stage holds after the most recent edge.
  logic            m_valid;
  logic            m_writes;
  reg_idx_t        m_rd;
  word_t           m_data;
  longint unsigned m_retired;
  stim_t           cur;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic void model_clear();
    m_valid   = 1'b0;
    m_writes  = 1'b0;
    m_rd      = '0;
    m_data    = '0;
    m_retired = 0;
  endfunction

  // One rising edge with the inputs in `cur`.
  function automatic void model_edge();
    if (m_valid && !cur.stall && !cur.flush) m_retired = m_retired + 1;
    if (cur.flush) begin
      m_valid  = 1'b0;
      m_writes = 1'b0;
    end else if (!cur.stall) begin
      m_valid  = cur.valid;
      m_writes = cur.valid && cur.reg_write;
      m_rd     = cur.rd;
      m_data   = cur.mem_to_reg ? cur.mem : cur.alu;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.data = m_data;
    e.fv   = m_valid && m_writes && (int'(m_rd) != ZERO_REG);
    e.frd  = m_rd;
    e.we   = (e.fv && !cur.stall) ? (reg_mask_t'(1) << m_rd) : '0;
    e.ret  = m_retired[31:0];
    e.ret4 = m_retired[3:0];
    return e;
  endfunction

  function automatic void apply(input stim_t s);
    bus.stall         = s.stall;
    bus.flush         = s.flush;
    bus.in_valid      = s.valid;
    bus.in_reg_write  = s.reg_write;
    bus.in_mem_to_reg = s.mem_to_reg;
    bus.in_rd         = s.rd;
    bus.in_alu_result = s.alu;
    bus.in_mem_data   = s.mem;
  endfunction

  function automatic stim_t mk(input logic v, input logic rw, input logic m2r,
                               input int rd, input word_t alu, input word_t mem,
                               input logic stall, input logic flush);
    stim_t s;
    s.valid      = v;
    s.reg_write  = rw;
    s.mem_to_reg = m2r;
    s.rd         = reg_idx_t'(rd);
    s.alu        = alu;
    s.mem        = mem;
    s.stall      = stall;
    s.flush      = flush;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall      = ($urandom_range(3) == 0);
    s.flush      = ($urandom_range(9) == 0);
    s.valid      = ($urandom_range(3) != 0);
    s.reg_write  = ($urandom_range(4) != 0);
    s.mem_to_reg = 1'($urandom_range(1));
    s.rd         = ($urandom_range(7) == 0) ? reg_idx_t'(ZERO_REG)
                                            : reg_idx_t'($urandom_range(31));
    s.alu        = {$urandom, $urandom};
    s.mem        = {$urandom, $urandom};
    return s;
  endfunction

  // One instruction slot: account for the edge just taken, then present new
  // inputs (and reset level) and queue the outputs expected for this cycle.
  task automatic cycle(input stim_t s, input logic rst_val);
    @(posedge clk);
    #1;
    if (!reset) model_clear();
    else model_edge();
    reset = rst_val;
    if (!rst_val) model_clear();
    cur = s;
    apply(s);
    exp_q.push_back(predict());
  endtask

  // Monitor: compare whatever the DUT presents on each falling edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("WriteData", bus.WriteData,          e.data);
        check("write_en",  64'(bus.write_en),      64'(e.we));
        check("fwd_valid", 64'(bus.fwd_valid),     64'(e.fv));
        check("fwd_rd",    64'(bus.fwd_rd),        64'(e.frd));
        check("fwd_data",  bus.fwd_data,           e.data);
        check("retired",   64'(bus.retired),       64'(e.ret));
        check("retired4",  64'(bus4.retired),      64'(e.ret4));
      end
    end
  end

  initial begin
    cur = mk(0, 0, 0, 0, '0, '0, 0, 0);
    apply(cur);
    model_clear();
    #2;

    // Reset held with inputs toggling: everything reads zero.
    repeat (6) cycle(rand_stim(), 1'b0);

    // Release reset; the very next edge captures the ALU write-back to x5.
    cycle(mk(1, 1, 0, 5,  64'h0000_0000_DEAD_BEEF, '0, 0, 0), 1'b1);
    // Load to XZR: data appears, enables and tap stay off.
    cycle(mk(1, 1, 1, 31, '0, 64'h1234, 0, 0), 1'b1);
    // Capture rd=7, then hold it for three stalled cycles while inputs move.
    cycle(mk(1, 1, 0, 7,  64'hA5, '0, 0, 0), 1'b1);
    repeat (3) cycle(mk(1, 1, 0, 9, 64'h99, '0, 1, 0), 1'b1);
    cycle(mk(1, 1, 0, 9,  64'h99, '0, 0, 0), 1'b1);
    // Stall and flush together on a held rd=3.
    cycle(mk(1, 1, 0, 3,  64'h33, '0, 0, 0), 1'b1);
    cycle(mk(1, 1, 0, 4,  64'h44, '0, 1, 1), 1'b1);
    cycle(mk(0, 0, 0, 0,  '0, '0, 0, 0), 1'b1);
    // Reset arriving mid-stall/flush clears at once.
    cycle(mk(1, 1, 0, 10, 64'hAA, '0, 0, 0), 1'b1);
    cycle(mk(1, 1, 0, 11, 64'hBB, '0, 1, 0), 1'b1);
    cycle(mk(1, 1, 0, 11, 64'hBB, '0, 1, 1), 1'b0);
    cycle(mk(1, 1, 0, 12, 64'hCC, '0, 0, 0), 1'b1);

    // Random traffic; the 4-bit instance wraps repeatedly along the way.
    repeat (400) cycle(rand_stim(), 1'b1);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- MEM/WB pipeline register and write-back driver for the 5-stage CPU.
- Captures MEM-stage results once per cycle and selects ALU result or load data.
- Drives the register file's shared 64-bit WriteData bus and a one-hot per-register write-enable vector, one enable for each 64-bit register.
- Also exports a forwarding tap and a retired-instruction counter.

Parameters:
- DATA_W, 64, width of datapath and WriteData.
- ADDR_W, 5, register-index width.
- NUM_REGS, 32, register count; width of write_en.
- ZERO_REG, 31, index of XZR; writes to it are always suppressed.
- CNT_W, 32, retired-counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; reset=0 clears state immediately.
- stall  in  1  hold all stage state this cycle.
- flush  in  1  replace captured instruction with a bubble.
- in_valid  in  1  MEM stage holds a real instruction.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 selects in_mem_data, 0 selects in_alu_result.
- in_rd  in  ADDR_W  destination register index.
- in_alu_result  in  DATA_W  ALU result from EX/MEM.
- in_mem_data  in  DATA_W  data-memory read data.
- WriteData  out  DATA_W  write-back data to the register file.
- write_en  out  NUM_REGS  one-hot register write enables.
- fwd_valid  out  1  forwarding tap is meaningful.
- fwd_rd  out  ADDR_W  forwarding destination index.
- fwd_data  out  DATA_W  equals WriteData.
- retired  out  CNT_W  count of instructions that left WB.

Behaviour:
- Reset (reset=0, asynchronous):
  - Internal wb_valid, wb_reg_write, wb_rd, and wb_data clear to 0; retired=0.
  - Outputs therefore read write_en=0, WriteData=0, fwd_valid=0, fwd_rd=0, fwd_data=0.
  - Reset deasserts asynchronously; first capture occurs on the next rising edge with reset=1.
- Data selection at capture: wb_data <= in_mem_to_reg ? in_mem_data : in_alu_result. Data is registered, so latency is 1 cycle from MEM inputs to WriteData.
- Per rising edge, priority flush > stall > normal:
  - flush=1: wb_valid<=0, wb_reg_write<=0; data and rd fields don't-care but held. flush overrides stall.
  - stall=1, flush=0: all wb_* hold their values.
  - otherwise: wb_valid<=in_valid; wb_reg_write<=in_valid & in_reg_write; wb_rd<=in_rd; wb_data<=selected data.
- write_en[i] = wb_valid & wb_reg_write & (wb_rd==i) & (i!=ZERO_REG), combinational from registered state.
  - At most one bit is set. All bits are 0 when wb_rd==ZERO_REG.
  - write_en is forced 0 while stall=1, so a held instruction writes the register file exactly once, on its first non-stalled cycle.
- WriteData = wb_data regardless of enables.
- Forwarding tap: fwd_valid = wb_valid & wb_reg_write & (wb_rd!=ZERO_REG); fwd_rd = wb_rd; fwd_data = wb_data. The tap is not gated by stall.
- retired increments by 1 on each rising edge where wb_valid=1 & stall=0 & flush=0. It counts bubbles never, wraps modulo 2^CNT_W, and holds otherwise.
- Reset mid-stall or mid-flush: reset wins; state is cleared immediately.

Decomposition:
- cpu_pkg holds DATA_W, ADDR_W, NUM_REGS, ZERO_REG, and typedefs reg_idx_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]).
- One sub-module, wb_decoder: ADDR_W-to-NUM_REGS one-hot decoder with an enable input and ZERO_REG masking. It produces write_en.
- All state lives in memwb_stage; there is no separate FSM module.

Test Plan:
- Reset: hold reset=0 with random inputs toggling -> write_en=0, WriteData=0, fwd_valid=0, retired=0 throughout. Release reset -> first edge captures the inputs.
- ALU write-back: in_valid=1, in_reg_write=1, in_mem_to_reg=0, in_rd=5, in_alu_result=64'h0000_0000_DEAD_BEEF -> next cycle write_en=32'h0000_0020, WriteData=64'hDEAD_BEEF, fwd_valid=1, fwd_rd=5; retired increments to 1 one edge later.
- Load write-back to XZR: in_mem_to_reg=1, in_rd=31, in_mem_data=64'h1234 -> next cycle WriteData=64'h1234, write_en=0, fwd_valid=0; retired still increments.
- Stall hold: capture rd=7, data=64'hA5; assert stall 3 cycles while inputs change to rd=9 -> write_en=0 during the stall, WriteData stays 64'hA5. Release stall -> write_en=32'h80 for exactly 1 cycle, then the rd=9 instruction follows; retired +1 for the held instruction only.
- Flush vs. stall: stall=1 and flush=1 on the same edge with valid rd=3 held -> next cycle wb_valid=0, write_en=0, fwd_valid=0, retired unchanged.
- Counter wrap: preload via 2^CNT_W-1 retirements (or force retired=32'hFFFF_FFFF) plus one valid non-stalled instruction -> retired=0.
